// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between a fetch port and a data port.
// Each access holds m_en for LATENCY cycles, then acks the owning port for one cycle.
module mem_arbiter #(
    parameter int unsigned LATENCY = 1,
    parameter bit          PRIO    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic {OwnFetch, OwnData} owner_e;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_data_q, i_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic i_cand, d_cand, grant, grant_data;

    always_comb begin
        // The owner still holds req during its ack cycle, so it may not compete then.
        i_cand = i_req && !(state_q == StResp && owner_q == OwnFetch);
        d_cand = d_req && !(state_q == StResp && owner_q == OwnData);
        grant  = (state_q != StAccess) && (i_cand || d_cand);
        if (i_cand && d_cand) begin
            grant_data = PRIO || (last_q == OwnFetch);
        end else begin
            grant_data = d_cand;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            StIdle: state_d = StIdle;
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    if (!rw_q) begin
                        if (owner_q == OwnData) d_rdata_d = m_rdata;
                        else                    i_data_d  = m_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                last_d  = owner_q;
            end
            default: state_d = StIdle;
        endcase

        // A grant from IDLE or RESP starts the next access immediately.
        if (grant) begin
            state_d = StAccess;
            cnt_d   = CntInit;
            owner_d = grant_data ? OwnData : OwnFetch;
            rw_d    = grant_data ? d_rw : 1'b0;
            addr_d  = grant_data ? d_addr : i_addr;
            wdata_d = grant_data ? d_wdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= OwnFetch;
            last_q    <= OwnData;
            cnt_q     <= 4'd0;
            rw_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            i_data_q  <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        m_en    = (state_q == StAccess);
        m_rw    = m_en && rw_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        i_ack   = (state_q == StResp) && (owner_q == OwnFetch);
        d_ack   = (state_q == StResp) && (owner_q == OwnData);
        i_data  = i_data_q;
        d_rdata = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts grant order, memory windows and ack
// data; a monitor checks every cycle against the scoreboard. A second instance covers PRIO=1.
module tb_mem_arbiter;

    localparam int LAT    = 2;
    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, d_req, d_rw, d_ack, m_en, m_rw;
    logic [31:0] i_addr, i_data, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        p_i_req, p_i_ack, p_d_req, p_d_rw, p_d_ack, p_m_en, p_m_rw;
    logic [31:0] p_i_addr, p_i_data, p_d_addr, p_d_wdata, p_d_rdata;
    logic [31:0] p_m_addr, p_m_wdata, p_m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .PRIO(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_arbiter #(.LATENCY(1), .PRIO(1'b1)) u_dut_p (
        .clk(clk), .reset(reset),
        .i_req(p_i_req), .i_addr(p_i_addr), .i_data(p_i_data), .i_ack(p_i_ack),
        .d_req(p_d_req), .d_rw(p_d_rw), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
        .d_rdata(p_d_rdata), .d_ack(p_d_ack),
        .m_en(p_m_en), .m_rw(p_m_rw), .m_addr(p_m_addr), .m_wdata(p_m_wdata),
        .m_rdata(p_m_rdata)
    );

    assign p_m_rdata = p_m_addr ^ 32'hC0DE_0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: written locations plus a fixed pattern everywhere else.
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        bit          port;  // 0 fetch, 1 data
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          grant;
    } txn_t;

    txn_t sbq[$];

    bit          i_pend = 1'b0, d_pend = 1'b0;
    int          i_vis = 0, d_vis = 0;
    bit          last_data = 1'b1;
    int          free_e = 0;
    bit          mon_on = 1'b0;
    bit          infl_v = 1'b0, infl_port = 1'b0;
    int          infl_ack = 0;
    logic [31:0] hold_i = '0, hold_d = '0, exp_maddr = '0, exp_mwdata = '0;

    // Reference model: the memory is a server; a granted access holds it for LAT cycles plus
    // one ack cycle, and waiting requests are picked by round-robin on ties.
    initial begin
        forever begin
            bit   iv, dv, pick;
            txn_t t;
            @(posedge clk);
            cyc++;
            if (reset) begin
                mon_on = 1'b1;
                if (infl_v && infl_ack >= cyc) begin
                    if (infl_port) d_pend = 1'b1;
                    else           i_pend = 1'b1;
                end
                infl_v     = 1'b0;
                sbq.delete();
                last_data  = 1'b1;
                free_e     = cyc + 1;
                hold_i     = '0;
                hold_d     = '0;
                exp_maddr  = '0;
                exp_mwdata = '0;
            end else if (cyc >= free_e) begin
                iv = i_pend && (i_vis <= cyc);
                dv = d_pend && (d_vis <= cyc);
                if (iv || dv) begin
                    pick    = (iv && dv) ? !last_data : dv;
                    t.port  = pick;
                    t.rw    = pick ? d_rw : 1'b0;
                    t.addr  = pick ? d_addr : i_addr;
                    t.wdata = pick ? d_wdata : 32'h0;
                    t.rdata = rd_mem(t.addr);
                    t.grant = cyc;
                    sbq.push_back(t);
                    if (pick) d_pend = 1'b0;
                    else      i_pend = 1'b0;
                    last_data = pick;
                    free_e    = cyc + LAT + 1;
                    infl_v    = 1'b1;
                    infl_port = pick;
                    infl_ack  = cyc + LAT;
                end
            end
        end
    end

    // Monitor: acts as the memory and checks the DUT every cycle against the scoreboard.
    initial begin
        m_rdata = '0;
        forever begin
            bit   in_acc, exp_rw, due;
            txn_t t;
            @(negedge clk);
            if (m_en === 1'b1 && m_rw === 1'b1) mem[m_addr] = m_wdata;
            if (mon_on) begin
                in_acc = 1'b0;
                exp_rw = 1'b0;
                if (sbq.size() > 0 && cyc >= sbq[0].grant && cyc < sbq[0].grant + LAT) begin
                    in_acc     = 1'b1;
                    exp_rw     = sbq[0].rw;
                    exp_maddr  = sbq[0].addr;
                    exp_mwdata = sbq[0].wdata;
                end
                check("m_en", m_en, in_acc);
                check("m_rw", m_rw, exp_rw);
                check("m_addr", m_addr, exp_maddr);
                check("m_wdata", m_wdata, exp_mwdata);
                due = (sbq.size() > 0) && (cyc >= sbq[0].grant + LAT);
                if (i_ack === 1'b1 || d_ack === 1'b1) begin
                    if (sbq.size() == 0) begin
                        check("ack_spurious", {i_ack, d_ack}, 2'b00);
                    end else begin
                        t = sbq.pop_front();
                        check("ack_port", {i_ack, d_ack}, t.port ? 2'b01 : 2'b10);
                        check("ack_cycle", cyc, t.grant + LAT);
                        if (!t.rw) begin
                            if (t.port) hold_d = t.rdata;
                            else        hold_i = t.rdata;
                        end
                    end
                end else begin
                    check("ack_idle", {i_ack, d_ack},
                          due ? (sbq[0].port ? 2'b01 : 2'b10) : 2'b00);
                    if (due) void'(sbq.pop_front());
                end
                check("i_data", i_data, hold_i);
                check("d_rdata", d_rdata, hold_d);
            end
            m_rdata = rd_mem(m_addr);
        end
    end

    task automatic fetch_txn(input logic [31:0] a, output int ack_at);
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = a;
        i_pend = 1'b1;
        i_vis  = cyc + 1;
        ack_at = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (i_ack === 1'b1) begin
                ack_at = cyc;
                break;
            end
        end
        vectors++;
        if (ack_at < 0) begin
            miscompares++;
            $display("FAIL fetch_timeout: no i_ack within %0d cycles (addr %h)", BUDGET, a);
        end
        i_req  = 1'b0;
        i_addr = $urandom;
    endtask

    task automatic data_txn(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                            output int ack_at);
        @(negedge clk);
        d_req   = 1'b1;
        d_rw    = rw;
        d_addr  = a;
        d_wdata = wd;
        d_pend  = 1'b1;
        d_vis   = cyc + 1;
        ack_at  = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin
                ack_at = cyc;
                break;
            end
        end
        vectors++;
        if (ack_at < 0) begin
            miscompares++;
            $display("FAIL data_timeout: no d_ack within %0d cycles (addr %h)", BUDGET, a);
        end
        d_req   = 1'b0;
        d_rw    = 1'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'(4 * $urandom_range(0, 7));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          fa, fb, da, r_at, fa_r, da_r;
        logic [3:0]  exp_ctl [7];
        logic [31:0] exp_adr [7];

        reset  = 1'b1;
        i_req  = 1'b0; i_addr = '0;
        d_req  = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
        p_i_req = 1'b0; p_i_addr = '0;
        p_d_req = 1'b0; p_d_rw = 1'b0; p_d_addr = '0; p_d_wdata = '0;
        mem[32'h1000] = 32'hDEAD_BEEF;

        // Reset held three cycles with both requests up; fetch must win after release.
        fork
            fetch_txn(32'h500, fa);
            data_txn(1'b0, 32'h504, 32'h0, da);
            begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("rst_ctl", {i_ack, d_ack, m_en, m_rw}, 4'b0000);
                    check("rst_rdata", {i_data, d_rdata}, 64'h0);
                    check("rst_mem", {m_addr, m_wdata}, 64'h0);
                end
                reset = 1'b0;
            end
        join
        check("rst_fetch_first", fa < da, 1'b1);

        fetch_txn(32'h1000, fa);
        check("fetch_data", i_data, 32'hDEAD_BEEF);

        data_txn(1'b1, 32'h20, 32'h41, da);
        data_txn(1'b0, 32'h20, 32'h0, da);
        check("readback", d_rdata, 32'h41);

        // Contention: fetch, then data back-to-back, then fetch again.
        fork
            begin
                fetch_txn(32'h1004, fa);
                fetch_txn(32'h1008, fb);
            end
            data_txn(1'b0, 32'h24, 32'h0, da);
        join
        check("contend_data_gap", da - fa, 3);
        check("contend_refetch_gap", fb - da, 3);

        // Reset during the second access cycle abandons the fetch; the held request retries.
        r_at = 0;
        fork
            fetch_txn(32'h1010, fa);
            begin
                repeat (3) @(negedge clk);
                reset = 1'b1;
                r_at  = cyc;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        check("rst_retry_ack", fa, r_at + 4);

        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fetch_txn(rand_addr(), fa_r);
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                data_txn(1'($urandom), rand_addr(), $urandom, da_r);
            end
        join

        // PRIO=1, LATENCY=1: simultaneous requests go to data; period is two cycles.
        exp_ctl = '{4'b1000, 4'b0001, 4'b1000, 4'b0010, 4'b0000, 4'b1100, 4'b0001};
        exp_adr = '{32'h400, 32'h400, 32'h300, 32'h300, 32'h300, 32'h404, 32'h404};
        @(negedge clk);
        p_i_req = 1'b1; p_i_addr = 32'h300;
        p_d_req = 1'b1; p_d_rw = 1'b0; p_d_addr = 32'h400; p_d_wdata = 32'h0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("p_ctl", {p_m_en, p_m_rw, p_i_ack, p_d_ack}, exp_ctl[k]);
            check("p_addr", p_m_addr, exp_adr[k]);
            if (k == 1) begin
                check("p_d_rdata", p_d_rdata, 32'hC0DE_0400);
                p_d_req = 1'b0;
            end
            if (k == 3) begin
                check("p_i_data", p_i_data, 32'hC0DE_0300);
                p_i_req = 1'b0;
            end
            if (k == 4) begin
                p_d_req = 1'b1; p_d_rw = 1'b1; p_d_addr = 32'h404; p_d_wdata = 32'h55;
            end
            if (k == 5) check("p_wdata", p_m_wdata, 32'h55);
            if (k == 6) begin
                check("p_d_rdata_hold", p_d_rdata, 32'hC0DE_0400);
                p_d_req = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory between the core's instruction-fetch port and its data (load/store) port. Each access is sequenced through a fixed-latency memory cycle, and the owning requester is acknowledged with a one-cycle pulse. The block sits between the core and the RAM/serial address space. It replaces the dual-port memory assumption with arbitration and wait states.

Parameters:
LATENCY, 1, number of cycles m_en is held per access; m_rdata is sampled at the end of the last one. Legal range 1..15.
PRIO, 0, 0 = round-robin between ports; 1 = data port always wins a tie.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  32  fetch address
i_data  out  32  fetch read data; valid in the i_ack cycle, held until the next fetch ack
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held with d_rw, d_addr and d_wdata stable until d_ack
d_rw  in  1  1 = write, 0 = read
d_addr  in  32  data address
d_wdata  in  32  write data
d_rdata  out  32  read data; valid in the d_ack cycle, updated only by reads
d_ack  out  1  one-cycle data completion pulse
m_en  out  1  memory enable
m_rw  out  1  memory write strobe; only ever 1 while m_en=1
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE; cnt=0; last_grant=DATA.
  - All outputs 0, including i_data, d_rdata, m_addr and m_wdata.
  - Overrides every other event in that cycle.
- States: IDLE, ACCESS, RESP. cnt is 4 bits.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate; latch owner, addr, rw, and wdata (rw=0 and wdata=0 for a fetch).
  - cnt<=LATENCY-1; go to ACCESS.
- ACCESS:
  - m_en=1, m_addr/m_wdata=latched values, m_rw=latched rw.
  - cnt>0: decrement.
  - cnt==0: if the owner was reading, capture m_rdata into i_data or d_rdata (owner's register only); go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle; m_en=0, m_rw=0.
  - Arbitration runs again, but the current owner's req is ignored in this cycle (its req is still high during its ack).
  - Other port requesting: latch it and go to ACCESS (back-to-back). Otherwise go to IDLE.
  - last_grant<=owner.
- Arbitration:
  - Only one port requesting: grant it.
  - Both requesting with PRIO=0: grant the port that is not last_grant. After reset, fetch wins the first tie.
  - Both requesting with PRIO=1: grant data.
- Latency: a req first sampled at edge k gives m_en=1 for cycles k..k+LATENCY-1 and ack in cycle k+LATENCY. Worst-case wait for the losing port is 2*(LATENCY+1) cycles.
- Outside ACCESS: m_en=0 and m_rw=0. m_addr/m_wdata hold their last value.
- At most one of i_ack and d_ack is high in any cycle. Writes assert d_ack but leave d_rdata unchanged.
- Reset mid-ACCESS or mid-RESP: return to IDLE next edge, no ack issued, transaction abandoned; the requester must re-issue it.
- A req dropped before ack is a protocol violation; the latched transaction completes and is acked anyway.

Test Plan:
- Reset: reset=1 for 3 cycles with i_req=d_req=1 -> every output 0 in all three cycles; after release, fetch is granted first.
- LATENCY=2 fetch: i_req with i_addr=0x1000, m_rdata=0xDEADBEEF -> m_en=1 and m_addr=0x1000, m_rw=0 for 2 cycles; i_ack pulse in the next cycle with i_data=0xDEADBEEF; d_ack stays 0.
- LATENCY=2 write: d_rw=1, d_addr=0x20, d_wdata=0x41 -> m_rw=1 and m_wdata=0x41 for exactly 2 cycles; single d_ack; d_rdata unchanged.
- PRIO=0 contention, both reqs held: fetch ack at cycle 3; data m_en on cycles 4-5 with no idle gap; d_ack at cycle 6; then fetch is granted again.
- PRIO=1: both reqs rise in the same IDLE cycle -> data is granted first.
- LATENCY=1 back-to-back: access period is 2 cycles.
- Reset pulse during the second ACCESS cycle of a fetch -> m_en=0 the next cycle, no i_ack; a re-issued fetch then completes with normal latency.
